// File: rtl/elevator_car_ctrl.sv
// Car-motion and request scheduler: latches floor calls, moves the car in SCAN order,
// and pulses open on arrival, then waits for the door controller to cycle before moving on.
module elevator_car_ctrl #(
  parameter int FLOORS = 8,
  parameter int TRAVEL = 3,
  parameter int FW     = $clog2(FLOORS)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [FLOORS-1:0] req,
  input  logic              close_n,
  output logic              open,
  output logic [FW-1:0]     floor,
  output logic              move_up,
  output logic              move_down,
  output logic              dir,
  output logic [FLOORS-1:0] pending
);

  localparam int CW = (TRAVEL > 1) ? $clog2(TRAVEL) : 1;

  typedef enum logic [2:0] {IDLE, MOVE, OPEN, WAIT_OPEN, WAIT_CLOSE} state_t;

  state_t            state_q, state_d;
  logic [FW-1:0]     floor_q, floor_d;
  logic              dir_q, dir_d;
  logic [FLOORS-1:0] pending_q, pending_d;
  logic [CW-1:0]     cnt_q, cnt_d;
  logic              open_q, open_d;
  logic              move_up_q, move_up_d;
  logic              move_down_q, move_down_d;
  logic [FW-1:0]     floor_step;

  // True when any pending floor lies strictly beyond f in the given direction.
  function automatic logic ahead_of(input logic [FLOORS-1:0] p, input logic [FW-1:0] f,
                                    input logic up);
    logic hit;
    hit = 1'b0;
    for (int i = 0; i < FLOORS; i++)
      if (up ? (i > int'(f)) : (i < int'(f))) hit = hit | p[i];
    return hit;
  endfunction

  assign floor_step = dir_q ? floor_q + FW'(1) : floor_q - FW'(1);

  always_comb begin
    state_d   = state_q;
    floor_d   = floor_q;
    dir_d     = dir_q;
    cnt_d     = cnt_q;
    pending_d = pending_q | req;
    // Calls for the floor being served are absorbed until the door has started cycling.
    if (state_q == OPEN || state_q == WAIT_OPEN) pending_d[floor_q] = 1'b0;

    case (state_q)
      IDLE: begin
        if (pending_q[floor_q]) begin
          state_d = OPEN;
        end else if (ahead_of(pending_q, floor_q, dir_q)) begin
          state_d = MOVE;
        end else if (|pending_q) begin
          dir_d   = ~dir_q;
          state_d = MOVE;
        end
      end
      MOVE: begin
        if (cnt_q == CW'(TRAVEL - 1)) begin
          cnt_d   = '0;
          floor_d = floor_step;
          if (pending_q[floor_step])                      state_d = OPEN;
          else if (ahead_of(pending_q, floor_step, dir_q)) state_d = MOVE;
          else                                            state_d = IDLE;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      OPEN:       state_d = WAIT_OPEN;
      WAIT_OPEN:  if (close_n)  state_d = WAIT_CLOSE;
      WAIT_CLOSE: if (!close_n) state_d = IDLE;
      default:    state_d = IDLE;
    endcase

    open_d      = (state_d == OPEN);
    move_up_d   = (state_d == MOVE) && dir_d;
    move_down_d = (state_d == MOVE) && !dir_d;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      floor_q     <= '0;
      dir_q       <= 1'b1;
      pending_q   <= '0;
      cnt_q       <= '0;
      open_q      <= 1'b0;
      move_up_q   <= 1'b0;
      move_down_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      floor_q     <= floor_d;
      dir_q       <= dir_d;
      pending_q   <= pending_d;
      cnt_q       <= cnt_d;
      open_q      <= open_d;
      move_up_q   <= move_up_d;
      move_down_q <= move_down_d;
    end
  end

  assign open      = open_q;
  assign floor     = floor_q;
  assign move_up   = move_up_q;
  assign move_down = move_down_q;
  assign dir       = dir_q;
  assign pending   = pending_q;

endmodule

// File: doc/elevator_car_ctrl.md
# elevator_car_ctrl

Car-motion and request-scheduling controller for the elevator design. Latches floor requests, moves the car floor by floor in a collective (SCAN) order, and emits a one-cycle `open` pulse on arrival. It sits directly upstream of `open_close_door`: it drives that block's `open` input and consumes its `close_n` status before moving again.

## Interface
Parameters:
- `FLOORS`, 8: number of floors, ≥2; floors numbered 0..FLOORS-1.
- `TRAVEL`, 3: clock cycles to move one floor, ≥1.
- `FW`, $clog2(FLOORS): floor index width (derived).

Ports (one clock; reset is asynchronous and active-high):
- `clk`  in  1  system clock, rising edge.
- `rst`  in  1  asynchronous active-high reset.
- `req`  in  FLOORS  floor request strobes; bit i requests floor i; any width/duration.
- `close_n`  in  1  door status from `open_close_door`: 1 = door open or in its open cycle, 0 = door closed.
- `open`  out  1  one-cycle door-open command to `open_close_door`.
- `floor`  out  FW  current floor.
- `move_up`  out  1  motor up, high in every MOVE cycle with dir = up.
- `move_down`  out  1  motor down, high in every MOVE cycle with dir = down.
- `dir`  out  1  travel direction, 1 = up.
- `pending`  out  FLOORS  latched outstanding requests.

## Operation
- Reset (async, any state): state IDLE, `floor`=0, `dir`=1, `pending`=0, travel counter `cnt`=0, `open`=0, `move_up`=`move_down`=0.
- Request latch, every edge: `pending <= pending | req`, except bit `floor` is cleared/not set while in OPEN or WAIT_OPEN. Requests in WAIT_CLOSE are latched normally.
- "Ahead": any pending bit above `floor` when dir=1, below when dir=0.
- States and transitions:
  - IDLE: if `pending[floor]` -> OPEN; else if ahead -> MOVE; else if any pending (behind) -> flip `dir`, MOVE; else stay.
  - MOVE: `cnt` counts 0..TRAVEL-1. At `cnt`=TRAVEL-1: `cnt`<=0, `floor`<=`floor`±1; next state OPEN if `pending` at the new floor, else MOVE if still ahead of the new floor, else IDLE.
  - OPEN: `open`=1 for exactly this cycle; `pending[floor]` cleared; -> WAIT_OPEN.
  - WAIT_OPEN: stay until `close_n`=1, then -> WAIT_CLOSE.
  - WAIT_CLOSE: stay until `close_n`=0, then -> IDLE.
- `floor` never leaves 0..FLOORS-1: direction flips only in IDLE, and MOVE starts only toward a pending floor.
- `open`, `move_up`, `move_down` are registered Moore outputs and never overlap.
- `dir` changes only in IDLE.

## Timing
- `req` sampled at edge ending cycle k; `pending` visible in cycle k+1 (IDLE decides); first MOVE/OPEN cycle k+2.
- From IDLE, a request d floors away gives `open`=1 in cycle k+2+d·TRAVEL; d=0 gives `open` in cycle k+2.
- `floor` updates at the edge ending the last MOVE cycle of each floor; MOVE is continuous through intermediate unrequested floors, with no IDLE gap.
- After `close_n` falls, one IDLE cycle precedes the next MOVE/OPEN.
- Request for the current floor arriving during WAIT_CLOSE: reopen via IDLE -> OPEN after the door closes.
- Simultaneous requests: all latched the same cycle. Service order: current floor first, then all ahead in `dir`, then reverse.
- Reset asserted mid-MOVE or while waiting: immediate return to reset values. A door still open externally is not tracked after reset.

## Test plan
- Reset: `rst`=1 mid-MOVE at floor 3 -> all outputs at reset values within the same cycle; after release with no `req`, IDLE, `floor`=0.
- Single trip, TRAVEL=3: `req`=8'b0000_0100 one cycle (cycle k) -> `move_up` high cycles k+2..k+7, `floor` 1 then 2, `open` high only cycle k+8. Door model returns `close_n` 1 then 0 -> IDLE, `pending`=0.
- Same-floor request: idle at floor 0, `req[0]` at cycle k -> `open` at cycle k+2, no motion. `req[0]` during WAIT_OPEN -> ignored. `req[0]` during WAIT_CLOSE -> second `open` pulse after `close_n` falls.
- SCAN order: car at floor 4 moving up with `req[6]` pending; assert `req[2]` and `req[7]` -> stops (`open`) at 6, then 7, then `dir`=0, stop at 2.
- Stop-on-pass: moving up 0->5, `req[3]` asserted while `floor`=1 -> stop and `open` at floor 3 before continuing to 5.
- Door hold: `close_n` held 1 for 50 cycles in WAIT_CLOSE with new requests pending -> no `move_up`/`move_down` until `close_n`=0.
